// File: rtl/diff_decode_mpsk.sv
// Differential decoder for M-ary DPSK symbols with optional Gray coding,
// per-frame reference reload and a legacy DQPSK bit-swap mode.
module diff_decode_mpsk #(
    parameter int unsigned SYM_W    = 2,
    parameter int unsigned GRAY     = 1,
    parameter int unsigned INIT_REF = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             in_sof,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_sof,
    output logic [CNT_W-1:0] sym_cnt
);

    localparam logic [SYM_W-1:0] InitRef = SYM_W'(INIT_REF);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    function automatic logic [SYM_W-1:0] gray2bin(input logic [SYM_W-1:0] g);
        logic [SYM_W-1:0] b;
        b = g;
        for (int i = 1; i < SYM_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic logic [SYM_W-1:0] bin2gray(input logic [SYM_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [SYM_W-1:0] out_sym_q, out_sym_d;
    logic             out_sof_q, out_sof_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [SYM_W-1:0] ref_q, ref_d;
    logic [SYM_W-1:0] raw_ref_q, raw_ref_d;

    logic             accept;
    logic             xfer;
    logic [SYM_W-1:0] phase;
    logic [SYM_W-1:0] ref_sel;
    logic [SYM_W-1:0] diff;
    logic [SYM_W-1:0] mod_sym;
    logic [SYM_W-1:0] raw_sel;
    logic [SYM_W-1:0] legacy_sym;
    logic             use_legacy;

    // Legacy swap rule only exists for DQPSK; other widths always use the modular path.
    if (SYM_W == 2) begin : g_legacy
        assign legacy_sym = (raw_sel[0] != raw_sel[1]) ?
                            {in_sym[0] ^ raw_sel[0], in_sym[1] ^ raw_sel[1]} :
                            (in_sym ^ raw_sel);
        assign use_legacy = mode;
    end else begin : g_no_legacy
        assign legacy_sym = '0;
        assign use_legacy = 1'b0;
    end

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        xfer     = out_valid_q && out_ready;

        phase   = (GRAY != 0) ? gray2bin(in_sym) : in_sym;
        ref_sel = in_sof ? InitRef : ref_q;
        raw_sel = in_sof ? InitRef : raw_ref_q;
        diff    = phase - ref_sel;
        mod_sym = (GRAY != 0) ? bin2gray(diff) : diff;

        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_sof_d   = out_sof_q;
        sym_cnt_d   = sym_cnt_q;
        ref_d       = ref_q;
        raw_ref_d   = raw_ref_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_sym_d   = use_legacy ? legacy_sym : mod_sym;
            out_sof_d   = in_sof;
            ref_d       = phase;
            raw_ref_d   = in_sym;
            if (in_sof) begin
                sym_cnt_d = CntOne;
            end else if (sym_cnt_q != '1) begin
                sym_cnt_d = sym_cnt_q + CntOne;
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_sof_q   <= 1'b0;
            sym_cnt_q   <= '0;
            ref_q       <= InitRef;
            raw_ref_q   <= InitRef;
        end else begin
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_sof_q   <= out_sof_d;
            sym_cnt_q   <= sym_cnt_d;
            ref_q       <= ref_d;
            raw_ref_q   <= raw_ref_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_sof   = out_sof_q;
    assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_diff_decode_mpsk.sv
// Directed bench for diff_decode_mpsk: binary DQPSK, Gray DQPSK, legacy mode,
// D8PSK with non-zero reference, backpressure, counter saturation and async reset.
module tb_diff_decode_mpsk;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    // Binary DQPSK, small counter
    logic       b_in_valid, b_in_ready, b_in_sof, b_mode, b_out_valid, b_out_ready, b_out_sof;
    logic [1:0] b_in_sym, b_out_sym;
    logic [2:0] b_sym_cnt;
    // Gray DQPSK
    logic        g_in_valid, g_in_ready, g_in_sof, g_mode, g_out_valid, g_out_ready, g_out_sof;
    logic [1:0]  g_in_sym, g_out_sym;
    logic [15:0] g_sym_cnt;
    // Binary D8PSK, INIT_REF=5
    logic       e_in_valid, e_in_ready, e_in_sof, e_mode, e_out_valid, e_out_ready, e_out_sof;
    logic [2:0] e_in_sym, e_out_sym;
    logic [3:0] e_sym_cnt;

    diff_decode_mpsk #(.SYM_W(2), .GRAY(0), .INIT_REF(0), .CNT_W(3)) u_bin (
        .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sym(b_in_sym), .in_sof(b_in_sof), .mode(b_mode), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_sym(b_out_sym), .out_sof(b_out_sof), .sym_cnt(b_sym_cnt)
    );

    diff_decode_mpsk #(.SYM_W(2), .GRAY(1), .INIT_REF(0), .CNT_W(16)) u_gray (
        .clk(clk), .rstn(rstn), .in_valid(g_in_valid), .in_ready(g_in_ready),
        .in_sym(g_in_sym), .in_sof(g_in_sof), .mode(g_mode), .out_valid(g_out_valid),
        .out_ready(g_out_ready), .out_sym(g_out_sym), .out_sof(g_out_sof), .sym_cnt(g_sym_cnt)
    );

    diff_decode_mpsk #(.SYM_W(3), .GRAY(0), .INIT_REF(5), .CNT_W(4)) u_d8 (
        .clk(clk), .rstn(rstn), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .in_sym(e_in_sym), .in_sof(e_in_sof), .mode(e_mode), .out_valid(e_out_valid),
        .out_ready(e_out_ready), .out_sym(e_out_sym), .out_sof(e_out_sof), .sym_cnt(e_sym_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rstn = 1'b0;
        b_in_valid = 0; b_in_sym = 0; b_in_sof = 0; b_mode = 0; b_out_ready = 1;
        g_in_valid = 0; g_in_sym = 0; g_in_sof = 0; g_mode = 0; g_out_ready = 1;
        e_in_valid = 0; e_in_sym = 0; e_in_sof = 0; e_mode = 1; e_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b_out_valid, b_out_sym, b_out_sof, b_sym_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_bin: got %h expected 00",
                     {b_out_valid, b_out_sym, b_out_sof, b_sym_cnt});
        end
        checks++;
        if ({e_out_valid, e_out_sym, e_out_sof, e_sym_cnt} !== 9'h000) begin
            errors++;
            $display("FAIL reset_d8: got %h expected 000",
                     {e_out_valid, e_out_sym, e_out_sof, e_sym_cnt});
        end
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", b_in_ready);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_binary();
        logic [1:0] syms [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
        logic [1:0] exps [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1; b_in_sym = syms[i]; b_in_sof = (i == 0); b_mode = 0;
            @(posedge clk);
            #1;
            checks++;
            if ({b_out_valid, b_out_sym, b_out_sof, b_sym_cnt} !==
                {1'b1, exps[i], i == 0, 3'(i + 1)}) begin
                errors++;
                $display("FAIL binary[%0d]: got v%b s%0d f%b c%0d expected v1 s%0d f%b c%0d", i,
                         b_out_valid, b_out_sym, b_out_sof, b_sym_cnt, exps[i], i == 0, i + 1);
            end
        end
        b_in_valid = 0;
        @(posedge clk);
        #1;
        checks++;
        if (b_out_valid !== 1'b0 || b_out_sym !== 2'd3 || b_sym_cnt !== 3'd4) begin
            errors++;
            $display("FAIL binary_drain: got v%b s%0d c%0d expected v0 s3 c4",
                     b_out_valid, b_out_sym, b_sym_cnt);
        end
    endtask

    task automatic test_gray();
        logic [1:0] syms [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00};
        logic [1:0] exps [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 6; i++) begin
            g_in_valid = 1; g_in_sym = syms[i]; g_in_sof = (i == 0);
            @(posedge clk);
            #1;
            checks++;
            if ({g_out_valid, g_out_sym, g_out_sof} !== {1'b1, exps[i], i == 0} ||
                g_sym_cnt !== 16'(i + 1)) begin
                errors++;
                $display("FAIL gray[%0d]: got v%b s%b f%b c%0d expected v1 s%b f%b c%0d", i,
                         g_out_valid, g_out_sym, g_out_sof, g_sym_cnt, exps[i], i == 0, i + 1);
            end
        end
        g_in_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_legacy();
        logic [1:0] syms [6] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
        logic [1:0] exps [6] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10};
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1; b_in_sym = syms[i]; b_in_sof = (i == 0); b_mode = 1;
            @(posedge clk);
            #1;
            checks++;
            if (b_out_valid !== 1'b1 || b_out_sym !== exps[i]) begin
                errors++;
                $display("FAIL legacy[%0d]: got v%b s%b expected v1 s%b", i,
                         b_out_valid, b_out_sym, exps[i]);
            end
        end
        b_in_valid = 0; b_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_d8psk();
        // First symbol has no sof: decoded against the reset reference of 5.
        logic [2:0] syms [5] = '{3'd6, 3'd5, 3'd2, 3'd7, 3'd0};
        logic       sofs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] exps [5] = '{3'd1, 3'd0, 3'd5, 3'd5, 3'd1};
        logic [3:0] cnts [5] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 5; i++) begin
            e_in_valid = 1; e_in_sym = syms[i]; e_in_sof = sofs[i];
            @(posedge clk);
            #1;
            checks++;
            if ({e_out_valid, e_out_sym, e_out_sof, e_sym_cnt} !==
                {1'b1, exps[i], sofs[i], cnts[i]}) begin
                errors++;
                $display("FAIL d8psk[%0d]: got v%b s%0d f%b c%0d expected v1 s%0d f%b c%0d", i,
                         e_out_valid, e_out_sym, e_out_sof, e_sym_cnt, exps[i], sofs[i], cnts[i]);
            end
        end
        e_in_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        b_in_valid = 1; b_in_sym = 2'd2; b_in_sof = 1; b_mode = 0; b_out_ready = 1;
        @(posedge clk);
        #1;
        b_out_ready = 0; b_in_sym = 2'd3; b_in_sof = 0;
        #1;
        checks++;
        if (b_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b expected 0", b_in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({b_out_valid, b_out_sym, b_out_sof, b_sym_cnt, b_in_ready} !==
                {1'b1, 2'd2, 1'b1, 3'd1, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v%b s%0d f%b c%0d r%b expected v1 s2 f1 c1 r0",
                         i, b_out_valid, b_out_sym, b_out_sof, b_sym_cnt, b_in_ready);
            end
        end
        b_out_ready = 1;
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", b_in_ready);
        end
        @(posedge clk);
        #1;
        b_in_valid = 0;
        checks++;
        if ({b_out_valid, b_out_sym, b_out_sof, b_sym_cnt} !== {1'b1, 2'd1, 1'b0, 3'd2}) begin
            errors++;
            $display("FAIL bp_next: got v%b s%0d f%b c%0d expected v1 s1 f0 c2",
                     b_out_valid, b_out_sym, b_out_sof, b_sym_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({b_out_valid, b_out_sym, b_sym_cnt} !== {1'b0, 2'd1, 3'd2}) begin
            errors++;
            $display("FAIL bp_drain: got v%b s%0d c%0d expected v0 s1 c2",
                     b_out_valid, b_out_sym, b_sym_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 10; i++) begin
            b_in_valid = 1; b_in_sym = 2'd1; b_in_sof = (i == 0); b_mode = 0;
            @(posedge clk);
            #1;
            checks++;
            if (b_sym_cnt !== 3'((i < 7) ? i + 1 : 7)) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, b_sym_cnt,
                         (i < 7) ? i + 1 : 7);
            end
        end
        // Reference is 1 here; sof must decode 3 against INIT_REF=0.
        b_in_sym = 2'd3; b_in_sof = 1;
        @(posedge clk);
        #1;
        b_in_valid = 0;
        checks++;
        if ({b_out_sym, b_out_sof, b_sym_cnt} !== {2'd3, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL sat_reload: got s%0d f%b c%0d expected s3 f1 c1",
                     b_out_sym, b_out_sof, b_sym_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        b_in_valid = 1; b_in_sym = 2'd1; b_in_sof = 1; b_mode = 0;
        @(posedge clk);
        #1;
        b_in_sym = 2'd2; b_in_sof = 0;
        @(posedge clk);
        #1;
        b_in_valid = 0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_sym !== 2'd1) begin
            errors++;
            $display("FAIL arst_pre: got v%b s%0d expected v1 s1", b_out_valid, b_out_sym);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({b_out_valid, b_out_sym, b_out_sof, b_sym_cnt} !== 7'd0) begin
            errors++;
            $display("FAIL arst_async: got v%b s%0d f%b c%0d expected all zero",
                     b_out_valid, b_out_sym, b_out_sof, b_sym_cnt);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        b_in_valid = 1; b_in_sym = 2'd3; b_in_sof = 0;
        @(posedge clk);
        #1;
        b_in_valid = 0;
        checks++;
        if ({b_out_valid, b_out_sym, b_out_sof, b_sym_cnt} !== {1'b1, 2'd3, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL arst_after: got v%b s%0d f%b c%0d expected v1 s3 f0 c1",
                     b_out_valid, b_out_sym, b_out_sof, b_sym_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_binary();
        test_gray();
        test_legacy();
        test_d8psk();
        test_backpressure();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
